// File: rtl/res_st_sched.sv
// Reservation station: allocates free slots, wakes operands from CDB broadcasts, issues the oldest ready entry.
// Latency: alloc (or CDB wakeup) at edge N -> issuable in cycle N+1; issue is combinational from registered state.
// Backpressure: alloc_ready drops when full, flushing or in reset; entries stay put while issue_ready=0.
// Ports: clk/rst (sync, active-low), flush; alloc_* dispatch handshake + payload, alloc_idx target slot;
//        cdb_valid/cdb_tag/cdb_data packed broadcast channels (ch0 in LSBs); issue_* FU handshake + payload;
//        count/full/empty occupancy status.
module res_st_sched #(
  parameter int RES_ST_DEPTH = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int TAG_WIDTH    = 5,
  parameter int OP_WIDTH     = 13,
  parameter int A_WIDTH      = 32,
  parameter int CDB_COUNT    = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             alloc_valid,
  output logic                             alloc_ready,
  input  logic [OP_WIDTH-1:0]              alloc_op,
  input  logic [DATA_WIDTH-1:0]            alloc_vj,
  input  logic [DATA_WIDTH-1:0]            alloc_vk,
  input  logic [TAG_WIDTH-1:0]             alloc_qj,
  input  logic [TAG_WIDTH-1:0]             alloc_qk,
  input  logic [A_WIDTH-1:0]               alloc_a,
  input  logic [TAG_WIDTH-1:0]             alloc_dest,
  output logic [$clog2(RES_ST_DEPTH)-1:0]  alloc_idx,
  input  logic [CDB_COUNT-1:0]             cdb_valid,
  input  logic [CDB_COUNT*TAG_WIDTH-1:0]   cdb_tag,
  input  logic [CDB_COUNT*DATA_WIDTH-1:0]  cdb_data,
  output logic                             issue_valid,
  input  logic                             issue_ready,
  output logic [OP_WIDTH-1:0]              issue_op,
  output logic [DATA_WIDTH-1:0]            issue_vj,
  output logic [DATA_WIDTH-1:0]            issue_vk,
  output logic [A_WIDTH-1:0]               issue_a,
  output logic [TAG_WIDTH-1:0]             issue_dest,
  output logic [$clog2(RES_ST_DEPTH)-1:0]  issue_idx,
  output logic [$clog2(RES_ST_DEPTH+1)-1:0] count,
  output logic                             full,
  output logic                             empty
);
  localparam int D  = RES_ST_DEPTH;
  localparam int IW = $clog2(RES_ST_DEPTH);
  localparam int CW = $clog2(RES_ST_DEPTH+1);

  logic [D-1:0]          busy_q, busy_d;
  logic [OP_WIDTH-1:0]   op_q   [D], op_d   [D];
  logic [DATA_WIDTH-1:0] vj_q   [D], vj_d   [D];
  logic [DATA_WIDTH-1:0] vk_q   [D], vk_d   [D];
  logic [TAG_WIDTH-1:0]  qj_q   [D], qj_d   [D];
  logic [TAG_WIDTH-1:0]  qk_q   [D], qk_d   [D];
  logic [A_WIDTH-1:0]    a_q    [D], a_d    [D];
  logic [TAG_WIDTH-1:0]  dest_q [D], dest_d [D];
  // age_q[i][j] = 1 means entry i is older than entry j
  logic [D-1:0]          age_q  [D], age_d  [D];
  logic [CW-1:0]         count_q, count_d;

  logic [D-1:0] ready;
  logic         free_found, sel_found, older;
  logic [IW-1:0] sel_idx;
  logic         alloc_fire, issue_fire;

  // Returns {hit, data}; scanning high to low lets the lowest matching channel win.
  function automatic logic [DATA_WIDTH:0] cdb_lookup(input logic [TAG_WIDTH-1:0] tag);
    logic [DATA_WIDTH:0] r;
    r = '0;
    for (int c = CDB_COUNT-1; c >= 0; c--) begin
      if (cdb_valid[c] && tag != '0 && cdb_tag[c*TAG_WIDTH +: TAG_WIDTH] == tag)
        r = {1'b1, cdb_data[c*DATA_WIDTH +: DATA_WIDTH]};
    end
    return r;
  endfunction

  // Lowest free slot, from registered busy so a slot freed this cycle is not reused yet.
  always_comb begin
    free_found = 1'b0;
    alloc_idx  = '0;
    for (int i = 0; i < D; i++) begin
      if (!busy_q[i] && !free_found) begin
        free_found = 1'b1;
        alloc_idx  = IW'(i);
      end
    end
  end

  assign full        = (count_q == CW'(D));
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign alloc_ready = rst & ~full & ~flush;
  assign alloc_fire  = alloc_valid & alloc_ready;

  // Oldest ready: the ready entry that no other ready entry is older than.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    older     = 1'b0;
    for (int i = 0; i < D; i++)
      ready[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
    for (int i = 0; i < D; i++) begin
      older = 1'b0;
      for (int j = 0; j < D; j++)
        if (ready[j] && age_q[j][i]) older = 1'b1;
      if (ready[i] && !older && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  assign issue_valid = rst & sel_found;
  assign issue_fire  = issue_valid & issue_ready;
  assign issue_idx   = sel_idx;
  assign issue_op    = op_q[sel_idx];
  assign issue_vj    = vj_q[sel_idx];
  assign issue_vk    = vk_q[sel_idx];
  assign issue_a     = a_q[sel_idx];
  assign issue_dest  = dest_q[sel_idx];

  always_comb begin : nxt
    logic [DATA_WIDTH:0] hj, hk;
    busy_d = busy_q;  op_d = op_q;  vj_d = vj_q;  vk_d = vk_q;
    qj_d   = qj_q;    qk_d = qk_q;  a_d  = a_q;   dest_d = dest_q;
    age_d  = age_q;
    hj = '0;
    hk = '0;
    for (int i = 0; i < D; i++) begin
      hj = cdb_lookup(qj_q[i]);
      hk = cdb_lookup(qk_q[i]);
      if (busy_q[i] && hj[DATA_WIDTH]) begin
        vj_d[i] = hj[DATA_WIDTH-1:0];
        qj_d[i] = '0;
      end
      if (busy_q[i] && hk[DATA_WIDTH]) begin
        vk_d[i] = hk[DATA_WIDTH-1:0];
        qk_d[i] = '0;
      end
    end
    if (issue_fire) busy_d[sel_idx] = 1'b0;
    if (alloc_fire) begin
      hj = cdb_lookup(alloc_qj);
      hk = cdb_lookup(alloc_qk);
      busy_d[alloc_idx] = 1'b1;
      op_d[alloc_idx]   = alloc_op;
      a_d[alloc_idx]    = alloc_a;
      dest_d[alloc_idx] = alloc_dest;
      vj_d[alloc_idx]   = hj[DATA_WIDTH] ? hj[DATA_WIDTH-1:0] : alloc_vj;
      qj_d[alloc_idx]   = hj[DATA_WIDTH] ? '0 : alloc_qj;
      vk_d[alloc_idx]   = hk[DATA_WIDTH] ? hk[DATA_WIDTH-1:0] : alloc_vk;
      qk_d[alloc_idx]   = hk[DATA_WIDTH] ? '0 : alloc_qk;
      // New entry is younger than everything currently busy (alloc slot itself is not busy).
      for (int j = 0; j < D; j++) age_d[j][alloc_idx] = busy_q[j];
      age_d[alloc_idx] = '0;
    end
    // Stale age bits of freed entries are harmless: selection only considers ready rows.
    if (flush) busy_d = '0;
    count_d = flush ? '0 : count_q + CW'(alloc_fire) - CW'(issue_fire);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q  <= '0;
      count_q <= '0;
      age_q   <= '{default: '0};
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      age_q   <= age_d;
    end
  end

  // Payload only matters while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    vj_q   <= vj_d;
    vk_q   <= vk_d;
    qj_q   <= qj_d;
    qk_q   <= qk_d;
    a_q    <= a_d;
    dest_q <= dest_d;
  end
endmodule

// File: tb/tb_res_st_sched.sv
module tb_res_st_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        alloc_valid = 1'b0;
  logic        alloc_ready;
  logic [12:0] alloc_op = '0;
  logic [31:0] alloc_vj = '0, alloc_vk = '0, alloc_a = '0;
  logic [4:0]  alloc_qj = '0, alloc_qk = '0, alloc_dest = '0;
  logic [2:0]  alloc_idx;
  logic [1:0]  cdb_valid = '0;
  logic [9:0]  cdb_tag = '0;
  logic [63:0] cdb_data = '0;
  logic        issue_valid;
  logic        issue_ready = 1'b0;
  logic [12:0] issue_op;
  logic [31:0] issue_vj, issue_vk, issue_a;
  logic [4:0]  issue_dest;
  logic [2:0]  issue_idx;
  logic [3:0]  count;
  logic        full, empty;

  typedef struct packed {
    logic [12:0] op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [31:0] a;
    logic [4:0]  dest;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  res_st_sched dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_op(alloc_op), .alloc_vj(alloc_vj), .alloc_vk(alloc_vk),
    .alloc_qj(alloc_qj), .alloc_qk(alloc_qk), .alloc_a(alloc_a),
    .alloc_dest(alloc_dest), .alloc_idx(alloc_idx),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_a(issue_a), .issue_dest(issue_dest), .issue_idx(issue_idx),
    .count(count), .full(full), .empty(empty)
  );

  // All tasks start and end at posedge+1; outputs are sampled on the negedge.
  task automatic do_alloc(input logic [12:0] op, input logic [31:0] vj, input logic [31:0] vk,
                          input logic [4:0] qj, input logic [4:0] qk, input logic [31:0] a,
                          input logic [4:0] dest, output logic ok, output logic [2:0] idx);
    alloc_op = op; alloc_vj = vj; alloc_vk = vk; alloc_qj = qj; alloc_qk = qk;
    alloc_a = a; alloc_dest = dest; alloc_valid = 1'b1;
    @(negedge clk);
    ok = alloc_ready;
    idx = alloc_idx;
    @(posedge clk); #1;
    alloc_valid = 1'b0;
  endtask

  task automatic take_issue(output logic got, output exp_t obs);
    got = 1'b0;
    obs = '0;
    issue_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (issue_valid === 1'b1) begin
        got = 1'b1;
        obs.op = issue_op; obs.vj = issue_vj; obs.vk = issue_vk;
        obs.a = issue_a; obs.dest = issue_dest;
      end
      @(posedge clk); #1;
      if (got) break;
    end
    issue_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk);
    n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL rst_alloc_ready: got %b want 0", alloc_ready); end
    n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL rst_issue_valid: got %b want 0", issue_valid); end
    n_cmp++; if ({count, empty, full} !== {4'd0, 1'b1, 1'b0})
      begin n_bad++; $display("FAIL rst_status: got count=%0d empty=%b full=%b want 0/1/0", count, empty, full); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", alloc_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_fill;
    logic ok, got; logic [2:0] idx; exp_t e, obs;
    for (int k = 0; k < 8; k++) begin
      do_alloc(13'(k), 32'(100 + k), 32'(200 + k), 5'd0, 5'd0, 32'(k * 3), 5'(k + 1), ok, idx);
      e.op = 13'(k); e.vj = 32'(100 + k); e.vk = 32'(200 + k); e.a = 32'(k * 3); e.dest = 5'(k + 1);
      exp_q.push_back(e);
      n_cmp++; if (ok !== 1'b1 || idx !== 3'(k))
        begin n_bad++; $display("FAIL fill_alloc%0d: got ok=%b idx=%0d want ok=1 idx=%0d", k, ok, idx, k); end
    end
    @(negedge clk);
    n_cmp++; if ({count, full, alloc_ready} !== {4'd8, 1'b1, 1'b0})
      begin n_bad++; $display("FAIL fill_full: got count=%0d full=%b ready=%b want 8/1/0", count, full, alloc_ready); end
    n_cmp++; if (issue_valid !== 1'b1 || issue_idx !== 3'd0)
      begin n_bad++; $display("FAIL fill_issue_idx: got vld=%b idx=%0d want 1/0", issue_valid, issue_idx); end
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      take_issue(got, obs);
      e = exp_q.pop_front();
      n_cmp++; if (got !== 1'b1 || obs !== e)
        begin n_bad++; $display("FAIL fill_drain%0d: got vld=%b dest=%0d vj=%0h want dest=%0d vj=%0h", k, got, obs.dest, obs.vj, e.dest, e.vj); end
    end
    @(negedge clk);
    n_cmp++; if (count !== 4'd0 || empty !== 1'b1)
      begin n_bad++; $display("FAIL fill_empty: got count=%0d empty=%b want 0/1", count, empty); end
    @(posedge clk); #1;
  endtask

  task automatic test_oldest_first;
    logic ok, got; logic [2:0] idx; exp_t ea, eb, e, obs;
    do_alloc(13'h11, 32'd5, 32'd10, 5'd3, 5'd0, 32'hA, 5'd10, ok, idx);
    ea.op = 13'h11; ea.vj = 32'd7; ea.vk = 32'd10; ea.a = 32'hA; ea.dest = 5'd10;
    do_alloc(13'h22, 32'd20, 32'd10, 5'd0, 5'd0, 32'hB, 5'd11, ok, idx);
    eb.op = 13'h22; eb.vj = 32'd20; eb.vk = 32'd10; eb.a = 32'hB; eb.dest = 5'd11;
    exp_q.push_back(eb);
    exp_q.push_back(ea);
    // Broadcast A's tag while the FU accepts: B is the only ready entry this cycle.
    cdb_valid = 2'b10; cdb_tag = {5'd3, 5'd0}; cdb_data = {32'd7, 32'd0};
    issue_ready = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    obs.op = issue_op; obs.vj = issue_vj; obs.vk = issue_vk; obs.a = issue_a; obs.dest = issue_dest;
    n_cmp++; if (issue_valid !== 1'b1 || obs !== e)
      begin n_bad++; $display("FAIL oldest_b_first: got vld=%b dest=%0d want dest=%0d", issue_valid, obs.dest, e.dest); end
    @(posedge clk); #1;
    cdb_valid = 2'b00; issue_ready = 1'b0;
    take_issue(got, obs);
    e = exp_q.pop_front();
    n_cmp++; if (got !== 1'b1 || obs !== e)
      begin n_bad++; $display("FAIL oldest_a_next: got dest=%0d vj=%0d vk=%0d want dest=%0d vj=%0d vk=%0d", obs.dest, obs.vj, obs.vk, e.dest, e.vj, e.vk); end
  endtask

  task automatic test_bypass;
    logic ok, got; logic [2:0] idx; exp_t e, obs;
    cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd4}; cdb_data = {32'd0, 32'h55};
    do_alloc(13'h33, 32'd1, 32'd2, 5'd4, 5'd4, 32'hC, 5'd12, ok, idx);
    cdb_valid = 2'b00;
    e.op = 13'h33; e.vj = 32'h55; e.vk = 32'h55; e.a = 32'hC; e.dest = 5'd12;
    exp_q.push_back(e);
    @(negedge clk);
    n_cmp++; if (issue_valid !== 1'b1)
      begin n_bad++; $display("FAIL bypass_latency: got issue_valid=%b want 1", issue_valid); end
    @(posedge clk); #1;
    take_issue(got, obs);
    e = exp_q.pop_front();
    n_cmp++; if (got !== 1'b1 || obs !== e)
      begin n_bad++; $display("FAIL bypass_data: got vj=%0h vk=%0h want vj=%0h vk=%0h", obs.vj, obs.vk, e.vj, e.vk); end
  endtask

  task automatic test_channel_conflict;
    logic ok, got; logic [2:0] idx; exp_t e, obs;
    do_alloc(13'h44, 32'd9, 32'd8, 5'd6, 5'd0, 32'hD, 5'd13, ok, idx);
    e.op = 13'h44; e.vj = 32'd1; e.vk = 32'd8; e.a = 32'hD; e.dest = 5'd13;
    exp_q.push_back(e);
    cdb_valid = 2'b11; cdb_tag = {5'd6, 5'd6}; cdb_data = {32'd2, 32'd1};
    @(negedge clk);
    n_cmp++; if (issue_valid !== 1'b0)
      begin n_bad++; $display("FAIL wake_same_cycle: got issue_valid=%b want 0", issue_valid); end
    @(posedge clk); #1;
    cdb_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if (issue_valid !== 1'b1)
      begin n_bad++; $display("FAIL wake_next_cycle: got issue_valid=%b want 1", issue_valid); end
    @(posedge clk); #1;
    take_issue(got, obs);
    e = exp_q.pop_front();
    n_cmp++; if (got !== 1'b1 || obs !== e)
      begin n_bad++; $display("FAIL chan_conflict: got vj=%0d want vj=%0d", obs.vj, e.vj); end
  endtask

  task automatic test_full_swap;
    logic ok, got; logic [2:0] idx; exp_t e, obs;
    for (int k = 0; k < 8; k++) begin
      do_alloc(13'(k + 8), 32'(300 + k), 32'(400 + k), 5'd0, 5'd0, 32'(k), 5'(k + 16), ok, idx);
      e.op = 13'(k + 8); e.vj = 32'(300 + k); e.vk = 32'(400 + k); e.a = 32'(k); e.dest = 5'(k + 16);
      exp_q.push_back(e);
    end
    issue_ready = 1'b1;
    alloc_op = 13'h7F; alloc_vj = 32'h99; alloc_vk = 32'h98; alloc_qj = '0; alloc_qk = '0;
    alloc_a = 32'hE; alloc_dest = 5'd30; alloc_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (alloc_ready !== 1'b0 || issue_idx !== 3'd0)
      begin n_bad++; $display("FAIL swap_full_ready: got ready=%b idx=%0d want 0/0", alloc_ready, issue_idx); end
    e = exp_q.pop_front();
    obs.op = issue_op; obs.vj = issue_vj; obs.vk = issue_vk; obs.a = issue_a; obs.dest = issue_dest;
    n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL swap_issue: got dest=%0d want %0d", obs.dest, e.dest); end
    @(posedge clk); #1;
    issue_ready = 1'b0; alloc_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (count !== 4'd7) begin n_bad++; $display("FAIL swap_count7: got %0d want 7", count); end
    @(posedge clk); #1;
    do_alloc(13'h7F, 32'h99, 32'h98, 5'd0, 5'd0, 32'hE, 5'd30, ok, idx);
    e.op = 13'h7F; e.vj = 32'h99; e.vk = 32'h98; e.a = 32'hE; e.dest = 5'd30;
    exp_q.push_back(e);
    n_cmp++; if (ok !== 1'b1 || idx !== 3'd0)
      begin n_bad++; $display("FAIL swap_realloc: got ok=%b idx=%0d want 1/0", ok, idx); end
    @(negedge clk);
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL swap_count8: got %0d want 8", count); end
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      take_issue(got, obs);
      e = exp_q.pop_front();
      n_cmp++; if (got !== 1'b1 || obs !== e)
        begin n_bad++; $display("FAIL swap_drain%0d: got vld=%b dest=%0d want dest=%0d", k, got, obs.dest, e.dest); end
    end
  endtask

  task automatic test_flush;
    logic ok; logic [2:0] idx;
    for (int k = 0; k < 5; k++) do_alloc(13'(k), 32'(k), 32'(k), 5'd0, 5'd0, 32'd0, 5'(k + 1), ok, idx);
    flush = 1'b1; alloc_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b want 0", alloc_ready); end
    @(posedge clk); #1;
    flush = 1'b0; alloc_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({count, empty, issue_valid, alloc_idx} !== {4'd0, 1'b1, 1'b0, 3'd0})
      begin n_bad++; $display("FAIL flush_state: got count=%0d empty=%b ivld=%b aidx=%0d want 0/1/0/0", count, empty, issue_valid, alloc_idx); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic ok; logic [2:0] idx;
    for (int k = 0; k < 5; k++) do_alloc(13'(k), 32'(k), 32'(k), 5'd0, 5'd0, 32'd0, 5'(k + 1), ok, idx);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (alloc_ready !== 1'b0 || issue_valid !== 1'b0)
      begin n_bad++; $display("FAIL rstmid_gate: got ready=%b ivld=%b want 0/0", alloc_ready, issue_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if ({count, empty, alloc_ready} !== {4'd0, 1'b1, 1'b0})
      begin n_bad++; $display("FAIL rstmid_state: got count=%0d empty=%b ready=%b want 0/1/0", count, empty, alloc_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (alloc_ready !== 1'b1 || issue_valid !== 1'b0)
      begin n_bad++; $display("FAIL rstmid_release: got ready=%b ivld=%b want 1/0", alloc_ready, issue_valid); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_fill;
    test_oldest_first;
    test_bypass;
    test_channel_conflict;
    test_full_swap;
    test_flush;
    test_reset_mid;
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_left: got %0d pending want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
